// File: rtl/concat_splitter.sv
// ---------------------------------------------------------------------------
// concat_splitter
//
// Unpacks a wide word made of NUM_BEATS equal-width fields into a stream of
// narrow beats. By default the most-significant field (f0 of {f0,...,fN-1})
// leaves first. One word is held at a time. A new word can be loaded on the
// same edge that hands off the last beat of the current word, so a continuous
// input stream produces beats with no bubble.
//
// Build option:
//   CONCAT_SPLITTER_LSB_FIRST_EN - when defined, the least-significant field
//                                  leaves first. o_index still counts
//                                  0..NUM_BEATS-1 in emission order.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst    - asynchronous active-low reset
//   i_valid  - input word valid
//   o_ready  - block accepts a word this cycle
//   i_data   - packed input word (WORD_WIDTH)
//   o_valid  - beat valid
//   i_ready  - consumer accepts beat
//   o_data   - current beat (BEAT_WIDTH), 0 when o_valid is low
//   o_index  - field number of current beat, 0 when o_valid is low
//   o_last   - current beat is the final field of the word
// ---------------------------------------------------------------------------
module concat_splitter #(
  parameter int BEAT_WIDTH = 4,
  parameter int NUM_BEATS  = 5,
  parameter int WORD_WIDTH = BEAT_WIDTH * NUM_BEATS,
  parameter int IDX_WIDTH  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WORD_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BEAT_WIDTH-1:0] o_data,
  output logic [IDX_WIDTH-1:0]  o_index,
  output logic                  o_last
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_BEATS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [WORD_WIDTH-1:0]   sr_reg, sr_next;
  logic [WORD_WIDTH-1:0]   sr_shifted;
  logic [IDX_WIDTH-1:0]    cnt_reg, cnt_next;
  logic [BEAT_WIDTH-1:0]   head;
  logic                    busy;
  logic                    last_beat;
  logic                    accept;
  logic                    beat_hs;

  // Shift the word by one field toward the output end, zero filling the
  // vacated field. Fields are indexed here from the LSB end (field gi sits at
  // bits gi*BEAT_WIDTH).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BEATS; gi++) begin : g_shift
`ifdef CONCAT_SPLITTER_LSB_FIRST_EN
      if (gi == NUM_BEATS - 1) begin : g_fill
        assign sr_shifted[gi*BEAT_WIDTH +: BEAT_WIDTH] = '0;
      end else begin : g_move
        assign sr_shifted[gi*BEAT_WIDTH +: BEAT_WIDTH] = sr_reg[(gi+1)*BEAT_WIDTH +: BEAT_WIDTH];
      end
`else
      if (gi == 0) begin : g_fill
        assign sr_shifted[gi*BEAT_WIDTH +: BEAT_WIDTH] = '0;
      end else begin : g_move
        assign sr_shifted[gi*BEAT_WIDTH +: BEAT_WIDTH] = sr_reg[(gi-1)*BEAT_WIDTH +: BEAT_WIDTH];
      end
`endif
    end
  endgenerate

`ifdef CONCAT_SPLITTER_LSB_FIRST_EN
  assign head = sr_reg[BEAT_WIDTH-1:0];
`else
  assign head = sr_reg[WORD_WIDTH-1 -: BEAT_WIDTH];
`endif

  assign busy      = (state_reg == BUSY);
  assign last_beat = busy && (cnt_reg == LAST_IDX);
  assign beat_hs   = busy && i_ready;
  // A new word fits either when empty or when the last beat leaves this cycle.
  assign o_ready   = !busy || (last_beat && i_ready);
  assign accept    = i_valid && o_ready;

  // Outputs are forced to zero whenever no beat is presented.
  assign o_valid = busy;
  assign o_data  = busy ? head : '0;
  assign o_index = busy ? cnt_reg : '0;
  assign o_last  = last_beat;

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      // Covers both the idle load and the back-to-back reload on the last beat.
      state_next = BUSY;
      sr_next    = i_data;
      cnt_next   = '0;
    end else if (beat_hs) begin
      if (last_beat) begin
        state_next = IDLE;
        sr_next    = '0;
        cnt_next   = '0;
      end else begin
        sr_next  = sr_shifted;
        cnt_next = cnt_reg + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sr_reg    <= sr_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_concat_splitter.sv
module tb_concat_splitter;

  localparam int BW = 4;
  localparam int NB = 5;
  localparam int WW = BW * NB;
  localparam int IW = 3;
  // {o_valid, o_data, o_index, o_last, o_ready} while empty
  localparam logic [9:0] IDLE_OUT = 10'b0_0000_000_0_1;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [WW-1:0] i_data  = '0;
  logic          o_ready, o_valid, o_last;
  logic [BW-1:0] o_data;
  logic [IW-1:0] o_index;

  logic          d_ivalid = 1'b0;
  logic          d_iready = 1'b0;
  logic [7:0]    d_idata  = '0;
  logic          d_oready, d_ovalid, d_olast;
  logic [7:0]    d_odata;
  logic [0:0]    d_oindex;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [BW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] d_q[$];

  always #5 clk = ~clk;

  concat_splitter #(.BEAT_WIDTH(BW), .NUM_BEATS(NB)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_index(o_index), .o_last(o_last)
  );

  concat_splitter #(.BEAT_WIDTH(8), .NUM_BEATS(1)) dut1 (
    .i_clk(clk), .i_rst(rst_n), .i_valid(d_ivalid), .o_ready(d_oready), .i_data(d_idata),
    .o_valid(d_ovalid), .i_ready(d_iready), .o_data(d_odata), .o_index(d_oindex), .o_last(d_olast)
  );

  // Scoreboard model: expected beats of one accepted word, in emission order.
  task automatic push_word(input logic [WW-1:0] w);
    beat_t b;
    for (int k = 0; k < NB; k++) begin
`ifdef CONCAT_SPLITTER_LSB_FIRST_EN
      b.data = w[k*BW +: BW];
`else
      b.data = w[WW-1-k*BW -: BW];
`endif
      b.idx  = IW'(k);
      b.last = (k == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic test_reset();
    i_valid = 1'b1; i_data = 20'h12345; i_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_valid, o_data, o_index, o_last, o_ready} !== IDLE_OUT) begin
      n_err++; $display("FAIL reset_state got=%b want=%b", {o_valid, o_data, o_index, o_last, o_ready}, IDLE_OUT);
    end
    n_cmp++;
    if ({d_ovalid, d_odata, d_oindex, d_olast, d_oready} !== 12'b0_00000000_0_0_1) begin
      n_err++; $display("FAIL reset_state_nb1 got=%b want=%b", {d_ovalid, d_odata, d_oindex, d_olast, d_oready}, 12'b0_00000000_0_0_1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; i_valid = 1'b0;
    $display("reset released");
  endtask

  task automatic test_split_order();
    beat_t e; logic [9:0] got, want; int cyc = 0; int act = 0; bit sent = 0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 20'hABCDE; i_ready = 1'b1;
    while (!(sent && exp_q.size() == 0) && cyc < 30) begin
      @(negedge clk); cyc++;
      got = {o_valid, o_data, o_index, o_last, o_ready};
      want = IDLE_OUT;
      if (exp_q.size() > 0) begin e = exp_q[0]; want = {1'b1, e.data, e.idx, e.last, e.last & i_ready}; act++; end
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL split {v,d,idx,last,rdy} got=%b want=%b", got, want); end
      else if (o_valid) $display("split beat d=%h idx=%0d last=%b", o_data, o_index, o_last);
      if (exp_q.size() > 0 && o_valid && i_ready) void'(exp_q.pop_front());
      if (i_valid && o_ready) begin push_word(i_data); sent = 1; end
      @(posedge clk); #1;
      if (sent) begin i_valid = 1'b0; i_data = 20'h55555; end
    end
    n_cmp++;
    if (exp_q.size() != 0 || act != 5) begin
      n_err++; $display("FAIL split_cycles got=%0d left=%0d want=5 left=0", act, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    beat_t e; logic [9:0] got, want; int cyc = 0; int act = 0; int ns = 0;
    logic [WW-1:0] src [2];
    src[0] = 20'h12345; src[1] = 20'h6789F;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = src[0]; i_ready = 1'b1;
    while (!(ns == 2 && exp_q.size() == 0) && cyc < 40) begin
      @(negedge clk); cyc++;
      got = {o_valid, o_data, o_index, o_last, o_ready};
      want = IDLE_OUT;
      if (exp_q.size() > 0) begin e = exp_q[0]; want = {1'b1, e.data, e.idx, e.last, e.last & i_ready}; act++; end
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL b2b {v,d,idx,last,rdy} got=%b want=%b", got, want); end
      else if (o_valid) $display("b2b beat d=%h idx=%0d last=%b", o_data, o_index, o_last);
      if (exp_q.size() > 0 && o_valid && i_ready) void'(exp_q.pop_front());
      if (i_valid && o_ready) begin
        if (ns > 0) begin
          n_cmp++;
          if ({o_index, o_last} !== {3'd4, 1'b1}) begin
            n_err++; $display("FAIL b2b_reload_edge got idx=%0d last=%b want idx=4 last=1", o_index, o_last);
          end
        end
        push_word(i_data); ns++;
      end
      @(posedge clk); #1;
      if (ns < 2) i_data = src[ns];
      else begin i_valid = 1'b0; i_data = '0; end
    end
    n_cmp++;
    if (exp_q.size() != 0 || act != 10) begin
      n_err++; $display("FAIL b2b_cycles got=%0d left=%0d want=10 left=0", act, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e; logic [9:0] got, want; int cyc = 0; int act = 0; bit sent = 0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 20'hABCDE; i_ready = 1'b1;
    while (!(sent && exp_q.size() == 0) && cyc < 40) begin
      @(negedge clk); cyc++;
      got = {o_valid, o_data, o_index, o_last, o_ready};
      want = IDLE_OUT;
      if (exp_q.size() > 0) begin e = exp_q[0]; want = {1'b1, e.data, e.idx, e.last, e.last & i_ready}; act++; end
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL bp {v,d,idx,last,rdy} got=%b want=%b", got, want); end
      else if (o_valid) $display("bp beat d=%h idx=%0d last=%b ready_in=%b", o_data, o_index, o_last, i_ready);
      if (exp_q.size() > 0 && o_valid && i_ready) void'(exp_q.pop_front());
      if (i_valid && o_ready) begin push_word(i_data); sent = 1; end
      @(posedge clk); #1;
      if (sent) begin i_valid = 1'b0; i_data = 20'h33333; end
      // Stall the third presented beat for three cycles.
      i_ready = !(act >= 2 && act <= 4);
    end
    n_cmp++;
    if (exp_q.size() != 0 || act != 8) begin
      n_err++; $display("FAIL bp_cycles got=%0d left=%0d want=8 left=0", act, exp_q.size());
    end
    i_ready = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset_mid_word();
    beat_t e; logic [9:0] got, want; int cyc = 0; int act = 0; bit sent = 0;
    @(posedge clk); #1;
    i_valid = 1'b1; i_data = 20'hABCDE; i_ready = 1'b1;
    while (!(sent && exp_q.size() == 3) && cyc < 20) begin
      @(negedge clk); cyc++;
      if (exp_q.size() > 0 && o_valid && i_ready) begin
        $display("pre-reset beat d=%h idx=%0d", o_data, o_index);
        void'(exp_q.pop_front());
      end
      if (i_valid && o_ready) begin push_word(i_data); sent = 1; end
      @(posedge clk); #1;
      if (sent) i_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_valid, o_data, o_index, o_last, o_ready} !== IDLE_OUT) begin
      n_err++; $display("FAIL midreset_async got=%b want=%b", {o_valid, o_data, o_index, o_last, o_ready}, IDLE_OUT);
    end else $display("mid-word reset asserted, outputs idle");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1; i_valid = 1'b1; i_data = 20'h00F0F;
    sent = 0; cyc = 0;
    while (!(sent && exp_q.size() == 0) && cyc < 30) begin
      @(negedge clk); cyc++;
      got = {o_valid, o_data, o_index, o_last, o_ready};
      want = IDLE_OUT;
      if (exp_q.size() > 0) begin e = exp_q[0]; want = {1'b1, e.data, e.idx, e.last, e.last & i_ready}; act++; end
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL postreset {v,d,idx,last,rdy} got=%b want=%b", got, want); end
      else if (o_valid) $display("post-reset beat d=%h idx=%0d last=%b", o_data, o_index, o_last);
      if (exp_q.size() > 0 && o_valid && i_ready) void'(exp_q.pop_front());
      if (i_valid && o_ready) begin push_word(i_data); sent = 1; end
      @(posedge clk); #1;
      if (sent) i_valid = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0 || act != 5 || cyc != 6) begin
      n_err++; $display("FAIL postreset_cycles got=%0d/%0d left=%0d want=5/6 left=0", act, cyc, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_single_beat();
    logic [7:0] e; logic [11:0] got, want; int cyc = 0; int act = 0; int ns = 0;
    logic [7:0] src [2];
    src[0] = 8'h5A; src[1] = 8'hC3;
    @(posedge clk); #1;
    d_ivalid = 1'b1; d_idata = src[0]; d_iready = 1'b1;
    while (!(ns == 2 && d_q.size() == 0) && cyc < 20) begin
      @(negedge clk); cyc++;
      got = {d_ovalid, d_odata, d_oindex, d_olast, d_oready};
      want = 12'b0_00000000_0_0_1;
      if (d_q.size() > 0) begin e = d_q[0]; want = {1'b1, e, 1'b0, 1'b1, d_iready}; act++; end
      n_cmp++;
      if (got !== want) begin n_err++; $display("FAIL nb1 {v,d,idx,last,rdy} got=%b want=%b", got, want); end
      else if (d_ovalid) $display("nb1 beat d=%h idx=%0d last=%b", d_odata, d_oindex, d_olast);
      if (d_q.size() > 0 && d_ovalid && d_iready) void'(d_q.pop_front());
      if (d_ivalid && d_oready) begin d_q.push_back(d_idata); ns++; end
      @(posedge clk); #1;
      if (ns < 2) d_idata = src[ns];
      else d_ivalid = 1'b0;
    end
    n_cmp++;
    if (d_q.size() != 0 || act != 2 || cyc != 3) begin
      n_err++; $display("FAIL nb1_throughput got=%0d/%0d left=%0d want=2/3 left=0", act, cyc, d_q.size());
    end
    d_q.delete();
  endtask

  initial begin
    test_reset();
    test_split_order();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_single_beat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/concat_splitter.md
# concat_splitter

Unpacks a wide word, built as a concatenation of equal-width fields, into a stream of narrow beats, most-significant field first. It is the inverse of packing fields with `{f0, f1, ..., fN-1}`: `f0` leaves first. It sits between a wide producer and a narrow consumer, with valid/ready handshakes on both sides. It holds one word and supports back-to-back words with no bubble.

## Interface
- `BEAT_WIDTH`, default 4: width of one field/beat; must be ≥1.
- `NUM_BEATS`, default 5: number of fields per word; must be ≥1.
- `WORD_WIDTH`, default `BEAT_WIDTH*NUM_BEATS`: derived; do not override.
- `IDX_WIDTH`, default `max(1, $clog2(NUM_BEATS))`: derived.
- `i_clk`  input  1  clock; all state updates on rising edge.
- `i_rst`  input  1  reset; asynchronous, active-low.
- `i_valid`  input  1  input word valid.
- `o_ready`  output  1  block can accept a word this cycle.
- `i_data`  input  WORD_WIDTH  packed word; field k occupies `[WORD_WIDTH-1-k*BEAT_WIDTH -: BEAT_WIDTH]`.
- `o_valid`  output  1  beat valid.
- `i_ready`  input  1  consumer accepts beat.
- `o_data`  output  BEAT_WIDTH  current beat.
- `o_index`  output  IDX_WIDTH  field number of current beat, 0..NUM_BEATS-1.
- `o_last`  output  1  current beat is final field of the word.

## Operation
- **States:** IDLE and BUSY. The block holds a WORD_WIDTH shift register `sr` and a beat counter `cnt`.
- **IDLE:**
  - `o_ready`=1 and `o_valid`=0.
  - When `i_valid` is high, load `sr`←`i_data`, set `cnt`←0, and go to BUSY.
- **BUSY:**
  - `o_valid`=1.
  - `o_data`=`sr[WORD_WIDTH-1 -: BEAT_WIDTH]`.
  - `o_index`=`cnt`.
  - `o_last`=(`cnt`==NUM_BEATS-1).
- **Beat handshake** (`o_valid & i_ready`) when not last: `sr`←`sr<<BEAT_WIDTH` (zero fill) and `cnt`←`cnt`+1.
- **Handshake on the last beat:**
  - If `i_valid` is high, load the new word, set `cnt`←0, and stay in BUSY.
  - Otherwise go to IDLE.
- **`o_ready` rule:** `o_ready` = IDLE | (BUSY & `o_last` & `i_ready`). It combinationally depends on `i_ready` only in this last-beat case.
- **Handshake stability:**
  - While `o_valid` is high and `i_ready` is low, `o_data`, `o_index` and `o_last` hold stable.
  - `o_valid` never drops without a handshake.
- **Outputs held at 0:** `o_index`, `o_last` and `o_data` are 0 whenever `o_valid`=0.
- **`NUM_BEATS`=1:** every beat has `o_last`=1 and `o_index`=0. The block then acts as a one-entry pipeline register with full throughput.
- **Reset assertion** (any time, including mid-word):
  - The partial word is discarded and the state goes to IDLE.
  - `o_valid`=0, `o_ready`=1, `o_data`=0, `o_index`=0, `o_last`=0.
  - `sr` and `cnt` are cleared.
- `i_data` is sampled only on an accepting edge. It is ignored otherwise.

## Timing
- **Latency:** a word accepted at edge N presents its first beat in the cycle after N (registered output). No combinational path from `i_data` to `o_data`.
- **Throughput:** one beat per cycle under `i_ready`=1. A continuous `i_valid` stream yields one word every NUM_BEATS cycles, with `o_valid` held high.
- **Backpressure:** each cycle of `i_ready`=0 stalls by exactly one cycle. No beat is dropped or duplicated.
- **Reset timing:** reset takes effect immediately (asynchronous). Release is synchronous to the next `i_clk` edge, and the first accept can occur on that edge.

## Configuration
- **`CONCAT_SPLITTER_LSB_FIRST_EN`**
  - **Defined:**
    - Field order reverses: `o_data`=`sr[BEAT_WIDTH-1:0]`.
    - Shift is `sr>>BEAT_WIDTH`, so field NUM_BEATS-1 (the least-significant) leaves first.
    - `o_index` still counts 0..NUM_BEATS-1 in emission order.
  - **Undefined (default):** MSB-first as described above.
  - **Unchanged either way:** handshake, latency and reset behaviour.

## Test plan
- **MSB-first split:** defaults; reset, then one word `i_data`=20'hABCDE with `i_ready`=1.
  - Beats are A, B, C, D, E on 5 consecutive cycles.
  - `o_index` is 0..4, with `o_last` only on E.
  - `o_ready`=0 during A–D.
- **Back-to-back words:** `i_valid` held with 20'h12345 then 20'h6789F, `i_ready`=1.
  - Output is 10 beats 1,2,3,4,5,6,7,8,9,F with no gap in `o_valid`.
  - The second word is accepted on the edge where beat 5 completes.
- **Backpressure:** word 20'hABCDE; drop `i_ready` for 3 cycles while C is presented.
  - C, `o_index`=2 hold stable for 3 cycles.
  - Then D, E follow. Total 8 cycles from first beat to last handshake.
- **Reset mid-word:** assert `i_rst`=0 after beat B is accepted.
  - Outputs go immediately to `o_valid`=0, `o_ready`=1, `o_data`=0.
  - After release, a new word 20'h00F0F emits 0,0,F,0,F.
- **Macro on:** `CONCAT_SPLITTER_LSB_FIRST_EN` defined, word 20'hABCDE.
  - Beats are E, D, C, B, A, with `o_index` 0..4 and `o_last` on A.
- **Degenerate case:** `NUM_BEATS`=1, `BEAT_WIDTH`=8, stream 8'h5A, 8'hC3 with `i_ready`=1.
  - Each beat appears one cycle after acceptance, with `o_last`=1 and `o_index`=0.
  - Sustained one word per cycle.
